// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path: widths, the
// lane-index width helper, the drain FIFO entry layout and job states.
package systolic_pkg;

  localparam int DW         = 16;
  localparam int LANE_W_MAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Lane index needs at least one bit even for a single lane.
  function automatic int lane_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef struct packed {
    logic [LANE_W_MAX-1:0] lane;
    logic                  sat;
    logic [DW-1:0]         data;
  } fifo_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } job_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO for drained results; the head entry is read straight
// from the storage registers so the output side never sees input paths.
module drain_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                push,
  input  logic [W-1:0]                        push_data,
  input  logic                                pop,
  output logic [W-1:0]                        head,
  output logic                                full,
  output logic                                empty,
  output logic [systolic_pkg::clog2(DEPTH):0] count
);
  import systolic_pkg::*;

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Captures PE results per lane, drains them round-robin into a FIFO and
// streams them out, counting emitted results against the job total.
module pe_result_drain #(
  parameter int NPE   = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [15:0]                           total_results,
  input  logic [NPE-1:0]                        se,
  input  logic [NPE*DW-1:0]                     s_out,
  input  logic [NPE-1:0]                        sat,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DW-1:0]                         out_data,
  output logic [systolic_pkg::lane_w(NPE)-1:0]  out_lane,
  output logic                                  out_sat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overrun
);
  import systolic_pkg::*;

  localparam int LW = lane_w(NPE);
  localparam int EW = LW + 1 + DW;

  logic [NPE-1:0]  pend_q, pend_d;
  logic [NPE-1:0]  lsat_q, lsat_d;
  logic [DW-1:0]   ldata_q [NPE];
  logic [DW-1:0]   ldata_d [NPE];
  logic [LW-1:0]   rr_q, rr_d;
  job_state_t      state_q, state_d;
  logic [15:0]     total_q, total_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ovr_q, ovr_d;

  logic            hi_vld, lo_vld, gnt_vld;
  logic [LW-1:0]   hi_idx, lo_idx, gnt_idx;
  logic [EW-1:0]   head;
  logic            f_full, f_empty, hs;
  logic [clog2(DEPTH):0] f_count;

  // Descending scan leaves the lowest pending index at or above the pointer
  // in hi_idx and the lowest overall in lo_idx (the wrap-around candidate).
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NPE - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_vld = 1'b1;
        lo_idx = LW'(i);
        if (LW'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = LW'(i);
        end
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
    gnt_vld = (hi_vld | lo_vld) & ~f_full & ~start;
  end

  always_comb begin
    pend_d  = pend_q;
    lsat_d  = lsat_q;
    ldata_d = ldata_q;
    ovr_d   = ovr_q;
    rr_d    = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == LW'(NPE - 1)) ? '0 : gnt_idx + LW'(1);
    for (int i = 0; i < NPE; i++) begin
      if (start) begin
        pend_d[i] = 1'b0;
      end else if (se[i]) begin
        // A lane being granted frees its register in the same cycle.
        if (!pend_q[i] || (gnt_vld && gnt_idx == LW'(i))) begin
          pend_d[i]  = 1'b1;
          lsat_d[i]  = sat[i];
          ldata_d[i] = s_out[i*DW +: DW];
        end else begin
          ovr_d = 1'b1;
        end
      end else if (gnt_vld && gnt_idx == LW'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
    if (start) ovr_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          total_d = total_results;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (start) begin
          total_d = total_results;
          cnt_d   = '0;
        end else if (total_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (hs) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == total_q) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      lsat_q  <= '0;
      for (int i = 0; i < NPE; i++) ldata_q[i] <= '0;
      rr_q    <= '0;
      state_q <= ST_IDLE;
      total_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      lsat_q  <= lsat_d;
      ldata_q <= ldata_d;
      rr_q    <= rr_d;
      state_q <= state_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  drain_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (gnt_vld),
    .push_data ({gnt_idx, lsat_q[gnt_idx], ldata_q[gnt_idx]}),
    .pop       (hs),
    .head      (head),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  // Stream contract: an entry transfers on a cycle with out_valid and
  // out_ready both high; while out_ready is low the head stays put.
  assign hs        = out_ready & ~f_empty;
  assign out_valid = (f_count != '0);
  assign out_lane  = out_valid ? head[EW-1 -: LW] : '0;
  assign out_sat   = out_valid ? head[DW] : 1'b0;
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign busy      = (state_q == ST_RUN);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized and directed stimulus for pe_result_drain, checked by a queue
// based reference model and a decoupled output monitor.
module tb_pe_result_drain;
  localparam int NPE   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 2;
  localparam int EW    = LW + 1 + DW;

  logic              clk = 1'b0;
  logic              rst, start, out_ready;
  logic [15:0]       total_results;
  logic [NPE-1:0]    se, sat;
  logic [NPE*DW-1:0] s_out;
  logic              out_valid, out_sat, busy, done, overrun;
  logic [DW-1:0]     out_data;
  logic [LW-1:0]     out_lane;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit done_seen = 1'b0;

  // Reference model state
  bit             m_pend [NPE];
  logic [DW-1:0]  m_hdata [NPE];
  bit             m_hsat [NPE];
  int             m_ptr, m_total, m_cnt;
  bit             m_run, m_ovr;
  logic [EW-1:0]  m_q [$];
  logic [EW-1:0]  exp_q [$];

  pe_result_drain #(.NPE(NPE), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .total_results (total_results),
    .se            (se),
    .s_out         (s_out),
    .sat           (sat),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane      (out_lane),
    .out_sat       (out_sat),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one update per clock edge, from the inputs held across that edge.
  initial begin
    bit exp_done, hs, g_found, pb [NPE];
    int g, l;
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      exp_done = 1'b0;
      if (rst) begin
        for (int i = 0; i < NPE; i++) m_pend[i] = 1'b0;
        m_q.delete(); exp_q.delete();
        m_ptr = 0; m_run = 1'b0; m_cnt = 0; m_total = 0; m_ovr = 1'b0;
      end else if (start) begin
        for (int i = 0; i < NPE; i++) m_pend[i] = 1'b0;
        m_q.delete(); exp_q.delete();
        m_run = 1'b1; m_total = int'(total_results); m_cnt = 0; m_ovr = 1'b0;
      end else begin
        hs = (m_q.size() != 0) && out_ready;
        exp_done = m_run && (m_total == 0 || (hs && m_cnt + 1 == m_total));
        g_found = 1'b0; g = 0;
        if (m_q.size() < DEPTH) begin
          for (int k = 0; k < NPE; k++) begin
            l = (m_ptr + k) % NPE;
            if (!g_found && m_pend[l]) begin g_found = 1'b1; g = l; end
          end
        end
        if (hs) void'(m_q.pop_front());
        for (int i = 0; i < NPE; i++) pb[i] = m_pend[i];
        if (g_found) begin
          e = {LW'(g), m_hsat[g], m_hdata[g]};
          m_q.push_back(e);
          exp_q.push_back(e);
          m_pend[g] = 1'b0;
          m_ptr = (g + 1) % NPE;
        end
        for (int i = 0; i < NPE; i++) begin
          if (se[i]) begin
            if (!pb[i] || (g_found && g == i)) begin
              m_pend[i] = 1'b1; m_hdata[i] = s_out[i*DW +: DW]; m_hsat[i] = sat[i];
            end else m_ovr = 1'b1;
          end
        end
        if (m_run) begin
          if (exp_done) m_run = 1'b0;
          else if (hs) m_cnt++;
        end
      end
      if (chk_en && !rst) chk("done", 32'(done_seen), 32'(exp_done));
    end
  end

  // Monitor: samples outputs mid-cycle and scores every handshake.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      done_seen = done;
      if (chk_en) begin
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("busy", 32'(busy), 32'(m_run));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'({out_lane, out_sat, out_data}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out_entry", 32'({out_lane, out_sat, out_data}), 32'(e));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    se    = '0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] v, input logic s);
    s_out[i*DW +: DW] = v;
    sat[i] = s;
  endtask

  task automatic do_start(input logic [15:0] t);
    start = 1'b1;
    total_results = t;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_lane"}, 32'(out_lane), 0);
    chk({tag, "_sat"}, 32'(out_sat), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; total_results = '0;
    se = '0; sat = '0; s_out = '0;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Single result on lane 2
    out_ready = 1'b1;
    do_start(16'd1);
    set_lane(2, 16'h1234, 1'b0); se = 4'b0100; step();
    idle(5);

    // Burst on all lanes, then lane 0 only, then another burst
    do_start(16'd9);
    for (int i = 0; i < NPE; i++) set_lane(i, DW'(i + 1), 1'b0);
    se = 4'b1111; step(); idle(6);
    set_lane(0, 16'h00A0, 1'b0); se = 4'b0001; step(); idle(3);
    for (int i = 0; i < NPE; i++) set_lane(i, DW'(16'h0010 + i), 1'b0);
    se = 4'b1111; step(); idle(6);

    // Backpressure: fill FIFO, stall a pending lane, overrun it, drain
    out_ready = 1'b0;
    do_start(16'd20);
    for (int i = 0; i < NPE; i++) set_lane(i, DW'(16'h0100 + i), 1'b0);
    se = 4'b1111; step(); idle(5);
    for (int i = 0; i < NPE; i++) set_lane(i, DW'(16'h0200 + i), i[0]);
    se = 4'b1111; step(); idle(5);
    set_lane(0, 16'hAAAA, 1'b0); se = 4'b0001; step(); idle(2);
    set_lane(0, 16'hBBBB, 1'b0); se = 4'b0001; step(); idle(2);
    out_ready = 1'b1;
    idle(14);

    // Same-cycle grant and capture on lane 0
    do_start(16'd4);
    set_lane(0, 16'h1111, 1'b0); se = 4'b0001; step();
    set_lane(0, 16'hBEEF, 1'b0); se = 4'b0001; step();
    idle(5);

    // Zero-length job, then restart mid-job with entries queued
    do_start(16'd0);
    idle(3);
    out_ready = 1'b0;
    do_start(16'd10);
    for (int i = 0; i < NPE; i++) set_lane(i, DW'(16'h0300 + i), 1'b0);
    se = 4'b0111; step(); idle(4);
    do_start(16'd5);
    idle(2);

    // Saturated result, then reset with the FIFO holding data
    out_ready = 1'b1;
    set_lane(3, 16'h7FFF, 1'b1); se = 4'b1000; step(); idle(4);
    out_ready = 1'b0;
    do_start(16'd5);
    set_lane(0, 16'h0400, 1'b1); set_lane(1, 16'h0401, 1'b0); se = 4'b0011; step(); idle(4);
    rst = 1'b1; step();
    chk_zero("midjob_reset");
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NPE; i++) begin
        se[i] = ($urandom_range(0, 3) == 0);
        set_lane(i, DW'($urandom), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 199) == 0) begin
        start = 1'b1;
        total_results = 16'($urandom_range(0, 12));
      end
      step();
    end

    out_ready = 1'b1;
    idle(40);
    chk("drain_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Downstream of a column of PEs. Captures each PE's accumulated result when its se pulse fires, together with its sat flag.
- Arbitrates among the PE lanes round-robin and buffers the captured results in an output FIFO.
- Presents the buffered results as a valid/ready stream to the result memory/host side.
- Counts emitted results against an expected total and signals job completion.

Parameters:
- NPE, 4, number of PE lanes drained (1..16).
- DW, 16, result width (matches PE s_out).
- DEPTH, 8, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start; flushes the block and loads total_results.
- total_results  in  16  results expected this job; sampled on start.
- se  in  NPE  per-lane result-valid pulse from the PEs.
- s_out  in  NPE*DW  per-lane results; lane i is bits [i*DW +: DW].
- sat  in  NPE  per-lane saturation flag, qualified by se.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DW  result.
- out_lane  out  clog2(NPE) (min 1)  source lane index.
- out_sat  out  1  saturation flag of the result.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the last expected result is handshaken.
- overrun  out  1  sticky: a result was lost; cleared by rst or start.

Behaviour:
- Reset (rst high at a clk edge): all lane pending flags 0, FIFO empty, emitted counter 0, RR pointer 0, state IDLE.
  - Outputs: out_valid=0, out_data=0, out_lane=0, out_sat=0, busy=0, done=0, overrun=0.
- Lane capture: each lane has a holding register {data, sat} and a pending flag.
  - se[i]=1 at an edge with pending[i]=0: load the register and set pending[i].
  - se[i]=1 while pending[i]=1 and the lane is not granted this cycle: drop the new value, keep the old one, set overrun.
  - se[i]=1 in the same cycle lane i is granted: no overrun; the new value is loaded and pending stays 1.
- Arbiter: combinational grant to the first pending lane at or after the RR pointer, wrapping at NPE-1→0.
  - A grant is issued only if the FIFO is not full (count before the edge).
  - On a grant, {lane, sat, data} is written to the FIFO, pending is cleared, and the pointer becomes grant+1 mod NPE.
  - At most one grant per cycle.
- Latency: se at cycle t → pending at t+1 → FIFO write at the edge ending t+1 → out_valid at t+2 if the FIFO was empty and no other lane was granted ahead.
- FIFO: DEPTH entries, count register of width clog2(DEPTH)+1.
  - Pop on out_valid & out_ready; push and pop may occur in the same cycle.
  - out_* are driven from the head entry, registered and not combinational from the inputs.
  - Data is held stable while out_valid=1 and out_ready=0.
  - out_valid = (count != 0).
- Job FSM:
  - IDLE:
    - Results are still captured and streamed; the emitted counter does not count.
    - start → RUN: load total, clear the counter, flush lanes and FIFO, clear overrun.
  - RUN:
    - busy=1; each output handshake increments the counter.
    - When a handshake makes counter == total: pulse done for one cycle and go to IDLE.
  - total_results=0 on start: enter RUN, then done pulses the next cycle and the FSM returns to IDLE.
  - start during RUN: restart the job, i.e. flush everything, reload total, stay in RUN, no done pulse.
  - se asserted in the same cycle as start is discarded because the flush has priority.
- Counter width 16; it never exceeds total in RUN.

Decomposition:
- Shared package systolic_pkg: DW constant (16), lane-index width function clog2, and the FIFO entry struct {lane, sat, data}.
- One sub-module: drain_fifo, a synchronous FIFO with DEPTH/width parameters, push/pop, full/empty/count, registered head.
- Lane registers, arbiter and FSM live in pe_result_drain.

Test Plan:
- Single result: start, total=1, se[2]=1 with s_out lane2=0x1234, sat=0, out_ready=1 → out_valid at +2 cycles, out_data=0x1234, out_lane=2, done pulse on that handshake, busy falls.
- Simultaneous se on all 4 lanes (values 1,2,3,4), out_ready=1 → outputs in lane order 0,1,2,3 on consecutive cycles; a second burst with the pointer at 1 after a lane-0-only grant starts from lane 1.
- Backpressure: out_ready=0, 8 results pushed over lanes → FIFO full, grants stall, pending stays set, no overrun.
  - Then a 9th se on an already-pending lane → overrun=1 and the first value is kept.
  - Raising out_ready → all 9 original entries drain, in order.
- Same-cycle grant + se: lane 0 pending and granted while se[0]=1 with 0xBEEF → no overrun, 0xBEEF emitted next, pending then 0.
- total_results=0 → done pulses the cycle after start; start mid-RUN with 3 entries queued → FIFO empty next cycle, out_valid=0, no done.
- Reset mid-job with FIFO non-empty → all outputs 0 the next cycle; sat=1 on a captured result → out_sat=1 on emission.
